hilo_commit_pipe: RTL and testbench



---
 rtl/hilo_commit_pipe.sv | 106 ++++++++++
 tb/tb_hilo_commit_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit_pipe.sv
// Carries EX results through EX/MEM and MEM/WB and commits HI/LO writes to the architectural pair.
// Latency: mem taps +1 edge, wb taps +2, hi_o/lo_o +3; stall[] holds or bubbles stages, flush bubbles both.
module hilo_commit_pipe #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [SW-1:0] stall,
  input  logic [AW-1:0] ex_wd,
  input  logic          ex_wreg,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_whilo,
  input  logic [DW-1:0] ex_hi,
  input  logic [DW-1:0] ex_lo,
  output logic [AW-1:0] mem_wd,
  output logic          mem_wreg,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_whilo,
  output logic [DW-1:0] mem_hi,
  output logic [DW-1:0] mem_lo,
  output logic [AW-1:0] wb_wd,
  output logic          wb_wreg,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_whilo,
  output logic [DW-1:0] wb_hi,
  output logic [DW-1:0] wb_lo,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  typedef struct packed {
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } ent_t;

  ent_t ex_ent;
  ent_t mem_q;
  ent_t wb_q;
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  assign ex_ent = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                    whilo: ex_whilo, hi: ex_hi, lo: ex_lo};

  // A stalled stage whose successor runs must emit a bubble, otherwise the
  // successor would consume the same entry twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (flush) begin
      mem_q <= '0;
    end else if (stall[3] && !stall[4]) begin
      mem_q <= '0;
    end else if (!stall[3]) begin
      mem_q <= ex_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (stall[4] && !stall[5]) begin
      wb_q <= '0;
    end else if (!stall[4]) begin
      wb_q <= mem_q;
    end
  end

  // The WB entry is older than anything a flush kills, so it commits regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_q.whilo) begin
      hi_q <= wb_q.hi;
      lo_q <= wb_q.lo;
    end
  end

  assign mem_wd    = mem_q.wd;
  assign mem_wreg  = mem_q.wreg;
  assign mem_wdata = mem_q.wdata;
  assign mem_whilo = mem_q.whilo;
  assign mem_hi    = mem_q.hi;
  assign mem_lo    = mem_q.lo;

  assign wb_wd     = wb_q.wd;
  assign wb_wreg   = wb_q.wreg;
  assign wb_wdata  = wb_q.wdata;
  assign wb_whilo  = wb_q.whilo;
  assign wb_hi     = wb_q.hi;
  assign wb_lo     = wb_q.lo;

  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_hilo_commit_pipe.sv
// Directed plus randomized bench for hilo_commit_pipe against a stage-level reference model.
module tb_hilo_commit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [4:0]  mem_wd, wb_wd;
  logic        mem_wreg, mem_whilo, wb_wreg, wb_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, wb_wdata, wb_hi, wb_lo, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t        m_mem, m_wb;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_commit_pipe #(.DW(32), .AW(5), .SW(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // What a stage holds after an edge, given its own stall bit and its successor's.
  function automatic ent_t stage_after(ent_t cur, ent_t src, logic me_stalled,
                                       logic next_stalled, logic fl);
    if (fl) return '0;
    if (!me_stalled) return src;
    if (!next_stalled) return '0;
    return cur;
  endfunction

  task automatic expect32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t o_mem, o_wb;
    o_mem = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, whilo: mem_whilo, hi: mem_hi, lo: mem_lo};
    o_wb  = '{wd: wb_wd, wreg: wb_wreg, wdata: wb_wdata, whilo: wb_whilo, hi: wb_hi, lo: wb_lo};
    checks++;
    assert (o_mem === m_mem) else begin
      errors++;
      $error("FAIL mem_stage: got %h want %h", o_mem, m_mem);
    end
    checks++;
    assert (o_wb === m_wb) else begin
      errors++;
      $error("FAIL wb_stage: got %h want %h", o_wb, m_wb);
    end
    expect32("hi_o_model", hi_o, m_hi);
    expect32("lo_o_model", lo_o, m_lo);
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    ent_t ex_e;
    ent_t n_mem, n_wb;
    ex_e = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo, hi: ex_hi, lo: ex_lo};
    @(posedge clk);
    if (rst) begin
      m_mem = '0; m_wb = '0; m_hi = '0; m_lo = '0;
    end else begin
      if (m_wb.whilo) begin
        m_hi = m_wb.hi;
        m_lo = m_wb.lo;
      end
      n_mem = stage_after(m_mem, ex_e,  stall[3], stall[4], flush);
      n_wb  = stage_after(m_wb,  m_mem, stall[4], stall[5], flush);
      m_mem = n_mem;
      m_wb  = n_wb;
    end
    #1;
    check_model();
  endtask

  task automatic set_ex(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    ex_wreg = wreg; ex_wd = wd; ex_wdata = wdata;
    ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
  endtask

  task automatic ex_bubble();
    set_ex(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    m_mem = '0; m_wb = '0; m_hi = '0; m_lo = '0;
    flush = 1'b0;
    stall = 6'b0;

    // Reset with garbage on the EX side
    rst = 1'b1;
    set_ex(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D, 32'hBAAD_BEEF);
    tick();
    tick();
    expect32("rst_hi_o", hi_o, 32'd0);
    expect32("rst_mem_whilo", {31'd0, mem_whilo}, 32'd0);
    expect32("rst_wb_wdata", wb_wdata, 32'd0);

    // First HI/LO write: latency through the taps
    rst = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    expect32("lat_mem_hi", mem_hi, 32'h1234_5678);
    expect32("lat_hi_early", hi_o, 32'd0);
    ex_bubble();
    tick();
    expect32("lat_wb_lo", wb_lo, 32'h9ABC_DEF0);
    tick();
    expect32("lat_hi_o", hi_o, 32'h1234_5678);
    expect32("lat_lo_o", lo_o, 32'h9ABC_DEF0);

    // Back-to-back mthi / mtlo style writes
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'hAAAA_0000, 32'd0);
    tick();
    expect32("b2b_mem_hi0", mem_hi, 32'hAAAA_0000);
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'hAAAA_0000, 32'h5555);
    tick();
    expect32("b2b_mem_lo1", mem_lo, 32'h5555);
    expect32("b2b_wb_lo0", wb_lo, 32'd0);
    ex_bubble();
    tick();
    expect32("b2b_wb_lo1", wb_lo, 32'h5555);
    tick();
    expect32("b2b_hi_o", hi_o, 32'hAAAA_0000);
    expect32("b2b_lo_o", lo_o, 32'h5555);

    // Stall bubble: EX stalled, MEM running
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h77, 32'h88);
    tick();
    stall = 6'b001111;
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h99, 32'h99);
    tick();
    expect32("sb_mem_whilo", {31'd0, mem_whilo}, 32'd0);
    expect32("sb_wb_hi", wb_hi, 32'h77);
    stall = 6'b0;
    ex_bubble();
    tick();
    expect32("sb_hi_o", hi_o, 32'h77);
    tick();
    expect32("sb_hi_o_kept", hi_o, 32'h77);

    // Stall hold: EX/MEM holds, MEM/WB bubbles, EX changes ignored
    set_ex(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
    tick();
    stall = 6'b011111;
    set_ex(1'b1, 5'd7, 32'h0BAD_0BAD, 1'b1, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect32("sh_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      expect32("sh_wb_wreg", {31'd0, wb_wreg}, 32'd0);
    end
    stall = 6'b0;
    ex_bubble();
    tick();
    expect32("sh_wb_wd", {27'd0, wb_wd}, 32'd5);
    expect32("sh_wb_wdata", wb_wdata, 32'hDEAD_BEEF);

    // Flush: WB entry commits, MEM entry is discarded
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h33, 32'h44);
    tick();
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h11, 32'h22);
    tick();
    flush = 1'b1;
    ex_bubble();
    tick();
    expect32("fl_mem_whilo", {31'd0, mem_whilo}, 32'd0);
    expect32("fl_wb_whilo", {31'd0, wb_whilo}, 32'd0);
    expect32("fl_hi_o", hi_o, 32'h33);
    expect32("fl_lo_o", lo_o, 32'h44);
    flush = 1'b0;
    tick();
    tick();
    expect32("fl_hi_o_after", hi_o, 32'h33);
    expect32("fl_lo_o_after", lo_o, 32'h44);

    // Reset while MEM/WB holds an uncommitted write
    set_ex(1'b0, 5'd0, 32'd0, 1'b1, 32'h55, 32'h66);
    tick();
    ex_bubble();
    tick();
    expect32("rm_wb_hi_pre", wb_hi, 32'h55);
    rst = 1'b1;
    tick();
    expect32("rm_hi_o", hi_o, 32'd0);
    expect32("rm_lo_o", lo_o, 32'd0);
    expect32("rm_wb_whilo", {31'd0, wb_whilo}, 32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic with stalls, flushes and the occasional reset
    for (int n = 0; n < 400; n++) begin
      set_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
      case ($urandom_range(0, 5))
        0: stall = 6'b001111;
        1: stall = 6'b011111;
        2: stall = 6'b111111;
        default: stall = 6'b000000;
      endcase
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
